// File: rtl/rob_state_core_pkg.sv
// Shared widths, RFT word field positions and instruction type encodings
// for the reorder-buffer storage core.
package rob_state_core_pkg;

  localparam int unsigned NREG  = 32;
  localparam int unsigned TAGW  = 5;
  localparam int unsigned RFT_W = 73;

  // RFT word field positions
  localparam int unsigned RFT_RD_MSB   = 72;
  localparam int unsigned RFT_RD_LSB   = 68;
  localparam int unsigned RFT_PC_MSB   = 67;
  localparam int unsigned RFT_PC_LSB   = 36;
  localparam int unsigned RFT_TYPE_MSB = 35;
  localparam int unsigned RFT_TYPE_LSB = 34;
  localparam int unsigned RFT_DATA_MSB = 33;
  localparam int unsigned RFT_DATA_LSB = 2;
  localparam int unsigned RFT_SV_BIT   = 1;
  localparam int unsigned RFT_V_BIT    = 0;

  localparam logic [1:0] INST_RD     = 2'b00;
  localparam logic [1:0] INST_BRANCH = 2'b01;
  localparam logic [1:0] INST_STORE  = 2'b10;

endpackage

// File: rtl/rob_order_fifo.sv
// Dispatch-order tag queue: circular FIFO with fall-through head and
// registered occupancy count.
module rob_order_fifo
  import rob_state_core_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  input  logic            oq_push,
  input  logic [TAGW-1:0] oq_din,
  input  logic            oq_pop,
  output logic [TAGW-1:0] oq_head,
  output logic            oq_full,
  output logic            oq_empty
);

  logic [TAGW-1:0] mem_q [NREG];
  logic [TAGW-1:0] rd_ptr_q;
  logic [TAGW-1:0] wr_ptr_q;
  logic [TAGW:0]   count_q;
  logic            push_ok;
  logic            pop_ok;

  assign oq_full  = (count_q == (TAGW+1)'(NREG));
  assign oq_empty = (count_q == '0);
  assign oq_head  = mem_q[rd_ptr_q];

  // A push at full is still taken when the head leaves in the same cycle
  always_comb begin
    pop_ok  = 1'b0;
    push_ok = 1'b0;
    pop_ok  = oq_pop && !oq_empty;
    push_ok = oq_push && (!oq_full || pop_ok);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= oq_din;
        wr_ptr_q        <= wr_ptr_q + TAGW'(1);
      end
      if (pop_ok) rd_ptr_q <= rd_ptr_q + TAGW'(1);
      if (push_ok && !pop_ok)      count_q <= count_q + (TAGW+1)'(1);
      else if (pop_ok && !push_ok) count_q <= count_q - (TAGW+1)'(1);
    end
  end

endmodule

// File: rtl/rob_status_table.sv
// Register status table: architectural register -> in-flight tag mapping,
// with associative clear on retire.
module rob_status_table
  import rob_state_core_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  input  logic [TAGW-1:0] rs_addr,
  input  logic [TAGW-1:0] rt_addr,
  output logic [TAGW-1:0] rs_tag,
  output logic [TAGW-1:0] rt_tag,
  output logic            rs_valid,
  output logic            rt_valid,
  input  logic            rst_wen,
  input  logic [TAGW-1:0] rst_waddr,
  input  logic [TAGW-1:0] rst_wdata,
  input  logic            retire_valid,
  input  logic [TAGW-1:0] retire_tag
);

  logic [TAGW-1:0] tag_q   [NREG];
  logic            valid_q [NREG];

  // Dispatch write is applied after the retire clear so it wins on a collision
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) begin
        tag_q[i]   <= '0;
        valid_q[i] <= 1'b0;
      end
    end else if (flush) begin
      for (int i = 0; i < NREG; i++) valid_q[i] <= 1'b0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (retire_valid && valid_q[i] && (tag_q[i] == retire_tag)) valid_q[i] <= 1'b0;
      end
      if (rst_wen) begin
        tag_q[rst_waddr]   <= rst_wdata;
        valid_q[rst_waddr] <= 1'b1;
      end
    end
  end

  assign rs_tag   = tag_q[rs_addr];
  assign rs_valid = valid_q[rs_addr];
  assign rt_tag   = tag_q[rt_addr];
  assign rt_valid = valid_q[rt_addr];

endmodule

// File: rtl/rob_temp_regfile.sv
// Temporary register file: one speculative-result word per tag, full-word
// allocate and partial result update.
module rob_temp_regfile
  import rob_state_core_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             rft_new,
  input  logic             rft_update,
  input  logic [TAGW-1:0]  rft_waddr,
  input  logic [RFT_W-1:0] rft_din,
  input  logic [TAGW-1:0]  rft_raddr1,
  input  logic [TAGW-1:0]  rft_raddr2,
  output logic [RFT_W-1:0] rft_dout1,
  output logic [RFT_W-1:0] rft_dout2
);

  logic [RFT_W-1:0] mem_q [NREG];

  // Update only touches spec_data and spec_valid; flush drops both valid bits
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < NREG; i++) mem_q[i][RFT_SV_BIT:RFT_V_BIT] <= 2'b00;
    end else if (rft_new) begin
      mem_q[rft_waddr] <= rft_din;
    end else if (rft_update) begin
      mem_q[rft_waddr][RFT_DATA_MSB:RFT_SV_BIT] <= rft_din[RFT_DATA_MSB:RFT_SV_BIT];
    end
  end

  assign rft_dout1 = mem_q[rft_raddr1];
  assign rft_dout2 = mem_q[rft_raddr2];

endmodule

// File: rtl/rob_state_core.sv
// Reorder-buffer storage core: register status table, order queue and
// temporary register file sharing one clock, reset and flush.
module rob_state_core
  import rob_state_core_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic [TAGW-1:0]  rs_addr,
  input  logic [TAGW-1:0]  rt_addr,
  output logic [TAGW-1:0]  rs_tag,
  output logic [TAGW-1:0]  rt_tag,
  output logic             rs_valid,
  output logic             rt_valid,
  input  logic             rst_wen,
  input  logic [TAGW-1:0]  rst_waddr,
  input  logic [TAGW-1:0]  rst_wdata,
  input  logic             retire_valid,
  input  logic [TAGW-1:0]  retire_tag,
  input  logic             oq_push,
  input  logic [TAGW-1:0]  oq_din,
  input  logic             oq_pop,
  output logic [TAGW-1:0]  oq_head,
  output logic             oq_full,
  output logic             oq_empty,
  input  logic             rft_new,
  input  logic             rft_update,
  input  logic [TAGW-1:0]  rft_waddr,
  input  logic [RFT_W-1:0] rft_din,
  input  logic [TAGW-1:0]  rft_raddr1,
  input  logic [TAGW-1:0]  rft_raddr2,
  output logic [RFT_W-1:0] rft_dout1,
  output logic [RFT_W-1:0] rft_dout2
);

  rob_status_table u_rst (
    .clock        (clock),
    .reset        (reset),
    .flush        (flush),
    .rs_addr      (rs_addr),
    .rt_addr      (rt_addr),
    .rs_tag       (rs_tag),
    .rt_tag       (rt_tag),
    .rs_valid     (rs_valid),
    .rt_valid     (rt_valid),
    .rst_wen      (rst_wen),
    .rst_waddr    (rst_waddr),
    .rst_wdata    (rst_wdata),
    .retire_valid (retire_valid),
    .retire_tag   (retire_tag)
  );

  rob_order_fifo u_oq (
    .clock    (clock),
    .reset    (reset),
    .flush    (flush),
    .oq_push  (oq_push),
    .oq_din   (oq_din),
    .oq_pop   (oq_pop),
    .oq_head  (oq_head),
    .oq_full  (oq_full),
    .oq_empty (oq_empty)
  );

  rob_temp_regfile u_rft (
    .clock      (clock),
    .reset      (reset),
    .flush      (flush),
    .rft_new    (rft_new),
    .rft_update (rft_update),
    .rft_waddr  (rft_waddr),
    .rft_din    (rft_din),
    .rft_raddr1 (rft_raddr1),
    .rft_raddr2 (rft_raddr2),
    .rft_dout1  (rft_dout1),
    .rft_dout2  (rft_dout2)
  );

endmodule

// File: tb/tb_rob_state_core.sv
// Directed bench for rob_state_core: RST map/retire, order queue, RFT
// new/update, flush and asynchronous reset.
module tb_rob_state_core;

  logic        clock = 1'b0;
  logic        reset;
  logic        flush;
  logic [4:0]  rs_addr, rt_addr, rs_tag, rt_tag;
  logic        rs_valid, rt_valid;
  logic        rst_wen;
  logic [4:0]  rst_waddr, rst_wdata;
  logic        retire_valid;
  logic [4:0]  retire_tag;
  logic        oq_push, oq_pop, oq_full, oq_empty;
  logic [4:0]  oq_din, oq_head;
  logic        rft_new, rft_update;
  logic [4:0]  rft_waddr, rft_raddr1, rft_raddr2;
  logic [72:0] rft_din, rft_dout1, rft_dout2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  rob_state_core dut (
    .clock        (clock),
    .reset        (reset),
    .flush        (flush),
    .rs_addr      (rs_addr),
    .rt_addr      (rt_addr),
    .rs_tag       (rs_tag),
    .rt_tag       (rt_tag),
    .rs_valid     (rs_valid),
    .rt_valid     (rt_valid),
    .rst_wen      (rst_wen),
    .rst_waddr    (rst_waddr),
    .rst_wdata    (rst_wdata),
    .retire_valid (retire_valid),
    .retire_tag   (retire_tag),
    .oq_push      (oq_push),
    .oq_din       (oq_din),
    .oq_pop       (oq_pop),
    .oq_head      (oq_head),
    .oq_full      (oq_full),
    .oq_empty     (oq_empty),
    .rft_new      (rft_new),
    .rft_update   (rft_update),
    .rft_waddr    (rft_waddr),
    .rft_din      (rft_din),
    .rft_raddr1   (rft_raddr1),
    .rft_raddr2   (rft_raddr2),
    .rft_dout1    (rft_dout1),
    .rft_dout2    (rft_dout2)
  );

  function automatic logic [72:0] word(input logic [4:0] rd, input logic [31:0] pc,
                                       input logic [1:0] ty, input logic [31:0] data,
                                       input logic sv, input logic v);
    return {rd, pc, ty, data, sv, v};
  endfunction

  task automatic check(input string tag, input logic [72:0] obs, input logic [72:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle before the next drive/sample
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    flush = 0; rst_wen = 0; retire_valid = 0; oq_push = 0; oq_pop = 0;
    rft_new = 0; rft_update = 0;
  endtask

  initial begin
    reset = 0; idle();
    rs_addr = 0; rt_addr = 0; rst_waddr = 0; rst_wdata = 0; retire_tag = 0;
    oq_din = 0; rft_waddr = 0; rft_din = '0; rft_raddr1 = 0; rft_raddr2 = 0;
    #1;
    check("reset_empty", 73'(oq_empty), 73'(1));
    check("reset_full", 73'(oq_full), 73'(0));
    check("reset_head", 73'(oq_head), 73'(0));
    check("reset_rs_valid", 73'(rs_valid), 73'(0));
    check("reset_rft", rft_dout1, '0);
    tick(); tick();
    reset = 1;
    tick();

    // RST map / associative retire / write-beats-retire
    rst_wen = 1; rst_waddr = 3; rst_wdata = 7; tick();
    rst_waddr = 5; rst_wdata = 7; tick();
    rst_waddr = 6; rst_wdata = 8; tick();
    rst_wen = 0; rs_addr = 3; rt_addr = 5; #1;
    check("rst_map_tag", 73'(rs_tag), 73'(7));
    check("rst_map_valid", 73'(rs_valid), 73'(1));
    check("rst_map_rt_tag", 73'(rt_tag), 73'(7));
    retire_valid = 1; retire_tag = 7; tick();
    retire_valid = 0; rt_addr = 6; #1;
    check("rst_retire_rs", 73'(rs_valid), 73'(0));
    rt_addr = 5; #1;
    check("rst_retire_assoc", 73'(rt_valid), 73'(0));
    rt_addr = 6; #1;
    check("rst_retire_other", {68'(rt_tag), 5'(rt_valid)}, {68'(8), 5'(1)});
    rst_wen = 1; rst_waddr = 3; rst_wdata = 7; tick();
    rst_wdata = 9; retire_valid = 1; retire_tag = 7; tick();
    rst_wen = 0; retire_valid = 0; #1;
    check("rst_wr_vs_retire_tag", 73'(rs_tag), 73'(9));
    check("rst_wr_vs_retire_valid", 73'(rs_valid), 73'(1));
    rst_wen = 1; rst_wdata = 9; retire_valid = 1; retire_tag = 9; tick();
    rst_wen = 0; retire_valid = 0; #1;
    check("rst_wr_beats_same_retire", 73'(rs_valid), 73'(1));

    // Order queue fill, overflow, push+pop at full, drain across wrap
    for (int i = 0; i < 32; i++) begin
      oq_push = 1; oq_din = 5'(i); tick();
    end
    oq_push = 0; #1;
    check("oq_full_after_32", 73'(oq_full), 73'(1));
    check("oq_head_after_fill", 73'(oq_head), 73'(0));
    oq_push = 1; oq_din = 5'd20; tick();
    oq_push = 0; #1;
    check("oq_push_at_full_ignored", {71'(oq_head), oq_full, oq_empty}, {71'(0), 1'b1, 1'b0});
    oq_push = 1; oq_pop = 1; oq_din = 5'd17; tick();
    oq_push = 0; oq_pop = 0; #1;
    check("oq_pushpop_full_stays", 73'(oq_full), 73'(1));
    check("oq_pushpop_head", 73'(oq_head), 73'(1));
    for (int i = 0; i < 32; i++) begin
      check($sformatf("oq_pop_%0d", i), 73'(oq_head), (i < 31) ? 73'(i + 1) : 73'(17));
      oq_pop = 1; tick();
      oq_pop = 0;
      if (i == 0) check("oq_not_full_after_pop", 73'(oq_full), 73'(0));
    end
    #1;
    check("oq_empty_after_drain", {71'(0), oq_full, oq_empty}, {71'(0), 1'b0, 1'b1});
    oq_pop = 1; tick();
    oq_pop = 0; oq_push = 1; oq_din = 5'd23; tick();
    oq_push = 0; #1;
    check("oq_pop_empty_ignored", {71'(oq_head), oq_full, oq_empty}, {71'(23), 1'b0, 1'b0});
    oq_pop = 1; tick();
    oq_pop = 0; #1;
    check("oq_empty_again", 73'(oq_empty), 73'(1));

    // RFT allocate, partial update, new beats update
    rft_new = 1; rft_waddr = 4; rft_din = word(5'd2, 32'h100, 2'b10, 32'h0, 1'b0, 1'b1); tick();
    rft_new = 0; rft_raddr1 = 4; #1;
    check("rft_new", rft_dout1, word(5'd2, 32'h100, 2'b10, 32'h0, 1'b0, 1'b1));
    rft_update = 1; rft_din = word(5'd31, 32'hFFFF_FFFF, 2'b01, 32'hDEADBEEF, 1'b1, 1'b0); tick();
    rft_update = 0; #1;
    check("rft_update", rft_dout1, word(5'd2, 32'h100, 2'b10, 32'hDEADBEEF, 1'b1, 1'b1));
    rft_new = 1; rft_update = 1; rft_waddr = 9;
    rft_din = word(5'd11, 32'h2000, 2'b01, 32'h1234_5678, 1'b0, 1'b1); tick();
    rft_new = 0; rft_update = 0; rft_raddr2 = 9; #1;
    check("rft_new_wins", rft_dout2, word(5'd11, 32'h2000, 2'b01, 32'h1234_5678, 1'b0, 1'b1));

    // Flush with concurrent push, RST write and RFT allocate
    for (int i = 0; i < 5; i++) begin
      oq_push = 1; oq_din = 5'(10 + i);
      rst_wen = 1; rst_waddr = 5'(i + 1); rst_wdata = 5'(20 + i); tick();
    end
    oq_push = 0; rst_wen = 0; rs_addr = 1; #1;
    check("pre_flush_head", 73'(oq_head), 73'(10));
    check("pre_flush_rs_valid", 73'(rs_valid), 73'(1));
    flush = 1; oq_push = 1; oq_pop = 1; oq_din = 5'd30;
    rst_wen = 1; rst_waddr = 6; rst_wdata = 5'd3;
    rft_new = 1; rft_waddr = 12; rft_din = word(5'd1, 32'h40, 2'b00, 32'h55, 1'b1, 1'b1); tick();
    idle(); #1;
    check("flush_empty", {71'(0), oq_full, oq_empty}, {71'(0), 1'b0, 1'b1});
    for (int r = 0; r < 32; r++) begin
      rs_addr = 5'(r); rft_raddr1 = 5'(r); #1;
      check($sformatf("flush_rs_valid_%0d", r), 73'(rs_valid), 73'(0));
      check($sformatf("flush_rft_v_%0d", r), 73'(rft_dout1[1:0]), 73'(0));
    end
    rft_raddr1 = 4; rft_raddr2 = 12; #1;
    check("flush_rft_keeps_payload", rft_dout1, word(5'd2, 32'h100, 2'b10, 32'hDEADBEEF, 1'b0, 1'b0));
    check("flush_blocks_rft_new", rft_dout2, '0);
    oq_push = 1; oq_din = 5'd6; tick();
    oq_push = 0; #1;
    check("post_flush_ptr_restart", {71'(oq_head), oq_full, oq_empty}, {71'(6), 1'b0, 1'b0});

    // Asynchronous reset in the middle of traffic
    oq_push = 1; oq_din = 5'd9; rst_wen = 1; rst_waddr = 8; rst_wdata = 5'd2;
    rft_new = 1; rft_waddr = 4; rft_din = word(5'd7, 32'h80, 2'b01, 32'hCAFE, 1'b1, 1'b1); tick();
    rs_addr = 8; rft_raddr1 = 4; #1;
    check("pre_reset_rs_valid", 73'(rs_valid), 73'(1));
    #1 reset = 0;
    #1;
    check("async_reset_empty", {71'(oq_head), oq_full, oq_empty}, {71'(0), 1'b0, 1'b1});
    check("async_reset_rs_valid", 73'(rs_valid), 73'(0));
    check("async_reset_rft", rft_dout1, '0);
    tick();
    check("reset_held_over_edge", 73'(oq_empty), 73'(1));
    idle();
    #2 reset = 1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
